// File: rtl/cluster_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : cluster_cmd_sched
// Description : Round-robin scheduler that takes commands from the HPU cores
//               and issues them into one registered output slot. Each core
//               has a limit on the number of commands not yet acknowledged.
//               Define CLUSTER_CMD_SCHED_STATS_EN to build the issue and stall
//               statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module cluster_cmd_sched #(
    parameter int NUM_CORES       = 8,
    parameter int CMD_WIDTH       = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CORE_ID_WIDTH   = $clog2(NUM_CORES)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_CORES-1:0]           cmd_valid_i,
    input  logic [NUM_CORES*CMD_WIDTH-1:0] cmd_i,
    output logic [NUM_CORES-1:0]           cmd_ready_o,
    output logic                           out_valid_o,
    output logic [CMD_WIDTH-1:0]           out_cmd_o,
    output logic [CORE_ID_WIDTH-1:0]       out_core_id_o,
    input  logic                           out_ready_i,
    input  logic                           resp_valid_i,
    input  logic [CORE_ID_WIDTH-1:0]       resp_core_id_i,
    output logic                           busy_o,
    output logic                           err_o,
    output logic [31:0]                    stat_issued_o,
    output logic [31:0]                    stat_stall_o
);

    localparam int c_CNT_W = 4;
    localparam int c_PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t                r_slot_state;
    slot_state_t                w_slot_state_next;
    logic [CMD_WIDTH-1:0]       r_out_cmd;
    logic [CORE_ID_WIDTH-1:0]   r_out_core_id;
    logic [c_PTR_W-1:0]         r_rr_ptr;
    logic [c_CNT_W-1:0]         r_outstanding [NUM_CORES];
    logic                       r_err;

    logic [NUM_CORES-1:0]       w_eligible;
    logic [NUM_CORES-1:0]       w_cnt_nz;
    logic                       w_grant_found;
    logic [c_PTR_W-1:0]         w_grant_idx;
    logic                       w_slot_free;
    logic                       w_grant;
    logic                       w_resp_in_range;
    logic                       w_resp_ok;

    // Per-core eligibility and outstanding-command bookkeeping.
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        logic w_inc;
        logic w_dec;

        assign w_eligible[i] = cmd_valid_i[i] &&
                               (r_outstanding[i] < c_CNT_W'(MAX_OUTSTANDING));
        assign w_cnt_nz[i]   = (r_outstanding[i] != '0);
        assign w_inc         = w_grant && (w_grant_idx == c_PTR_W'(i));
        assign w_dec         = w_resp_ok && (resp_core_id_i == CORE_ID_WIDTH'(i));

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_outstanding[i] <= '0;
            end else if (w_inc && !w_dec) begin
                r_outstanding[i] <= r_outstanding[i] + 1'b1;
            end else if (w_dec && !w_inc) begin
                r_outstanding[i] <= r_outstanding[i] - 1'b1;
            end
        end
    end

    // First eligible core at or after the rr pointer, wrapping around.
    always_comb begin
        int idx;
        idx           = 0;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_CORES;
            if (!w_grant_found && w_eligible[idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = c_PTR_W'(idx);
            end
        end
    end

    assign w_slot_free = (r_slot_state == SLOT_EMPTY) || out_ready_i;
    assign w_grant     = w_grant_found && w_slot_free && !rst_i;

    always_comb begin
        cmd_ready_o = '0;
        if (w_grant) begin
            cmd_ready_o[w_grant_idx] = 1'b1;
        end
    end

    // Responses against an idle or nonexistent core are protocol errors.
    assign w_resp_in_range = (int'(resp_core_id_i) < NUM_CORES);
    assign w_resp_ok       = resp_valid_i && w_resp_in_range &&
                             w_cnt_nz[resp_core_id_i];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_slot_state <= SLOT_EMPTY;
        end else begin
            r_slot_state <= w_slot_state_next;
        end
    end

    always_comb begin
        w_slot_state_next = r_slot_state;
        case (r_slot_state)
            SLOT_EMPTY: begin
                if (w_grant) begin
                    w_slot_state_next = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (out_ready_i && !w_grant) begin
                    w_slot_state_next = SLOT_EMPTY;
                end
            end
            default: w_slot_state_next = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_out_cmd     <= '0;
            r_out_core_id <= '0;
            r_rr_ptr      <= '0;
        end else if (w_grant) begin
            r_out_cmd     <= cmd_i[int'(w_grant_idx)*CMD_WIDTH +: CMD_WIDTH];
            r_out_core_id <= CORE_ID_WIDTH'(w_grant_idx);
            r_rr_ptr      <= (int'(w_grant_idx) == NUM_CORES - 1) ?
                             '0 : w_grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (resp_valid_i && !w_resp_ok) begin
            r_err <= 1'b1;
        end
    end

    assign out_valid_o   = (r_slot_state == SLOT_FULL);
    assign out_cmd_o     = r_out_cmd;
    assign out_core_id_o = r_out_core_id;
    assign busy_o        = |w_cnt_nz;
    assign err_o         = r_err;

`ifdef CLUSTER_CMD_SCHED_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_stall;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_grant && (r_stat_issued != '1)) begin
                r_stat_issued <= r_stat_issued + 1'b1;
            end
            if ((|cmd_valid_i) && !w_grant && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 1'b1;
            end
        end
    end

    assign stat_issued_o = r_stat_issued;
    assign stat_stall_o  = r_stat_stall;
`else
    assign stat_issued_o = '0;
    assign stat_stall_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cluster_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cluster_cmd_sched
// Description : Directed and random stimulus for cluster_cmd_sched, checked
//               against a cycle-level reference model of the scheduling rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cluster_cmd_sched;

    localparam int N    = 8;
    localparam int W    = 64;
    localparam int MAXO = 4;
    localparam int IDW  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     cmd_valid = '0;
    logic [N*W-1:0]   cmd_flat = '0;
    logic [N-1:0]     cmd_ready;
    logic             out_valid;
    logic [W-1:0]     out_cmd;
    logic [IDW-1:0]   out_core_id;
    logic             out_ready = 1'b0;
    logic             resp_valid = 1'b0;
    logic [IDW-1:0]   resp_id = '0;
    logic             busy;
    logic             err;
    logic [31:0]      stat_issued;
    logic [31:0]      stat_stall;

    cluster_cmd_sched #(
        .NUM_CORES(N), .CMD_WIDTH(W), .MAX_OUTSTANDING(MAXO), .CORE_ID_WIDTH(IDW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_i(cmd_flat), .cmd_ready_o(cmd_ready),
        .out_valid_o(out_valid), .out_cmd_o(out_cmd), .out_core_id_o(out_core_id),
        .out_ready_i(out_ready),
        .resp_valid_i(resp_valid), .resp_core_id_i(resp_id),
        .busy_o(busy), .err_o(err),
        .stat_issued_o(stat_issued), .stat_stall_o(stat_stall)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int           m_cnt [N];
    int           m_rr;
    bit           m_valid;
    logic [W-1:0] m_cmd;
    int           m_id;
    bit           m_err;
    longint       m_issued;
    longint       m_stall;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [N-1:0] obs_rdy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        if (m_valid && !out_ready) return -1;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (cmd_valid[c] && m_cnt[c] < MAXO) return c;
        end
        return -1;
    endfunction

    function automatic logic [63:0] exp_issued();
`ifdef CLUSTER_CMD_SCHED_STATS_EN
        return 64'(m_issued);
`else
        return 64'd0;
`endif
    endfunction

    function automatic logic [63:0] exp_stall();
`ifdef CLUSTER_CMD_SCHED_STATS_EN
        return 64'(m_stall);
`else
        return 64'd0;
`endif
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_rr = 0; m_valid = 0; m_cmd = '0; m_id = 0; m_err = 0;
        m_issued = 0; m_stall = 0;
    endtask

    task automatic check_outputs();
        bit exp_busy;
        exp_busy = 0;
        for (int i = 0; i < N; i++) if (m_cnt[i] != 0) exp_busy = 1;
        check("out_valid", out_valid, m_valid);
        check("out_cmd", out_cmd, m_cmd);
        check("out_core_id", out_core_id, m_id);
        check("busy", busy, exp_busy);
        check("err", err, m_err);
        check("stat_issued", stat_issued, exp_issued());
        check("stat_stall", stat_stall, exp_stall());
    endtask

    // One clock: check the grant, advance the model, check registered outputs.
    task automatic step();
        int           g;
        int           rid;
        bit           ok;
        logic [N-1:0] one;
        #1;
        one     = 1;
        g       = model_grant();
        obs_rdy = cmd_ready;
        check("cmd_ready", cmd_ready, (g >= 0) ? (one << g) : '0);
        rid = int'(resp_id);
        ok  = resp_valid && rid < N && m_cnt[rid] > 0;
        if (resp_valid && !ok) m_err = 1;
        if (ok) m_cnt[rid]--;
        if (g >= 0) begin
            m_cnt[g]++;
            m_valid = 1;
            m_cmd   = cmd_flat[g*W +: W];
            m_id    = g;
            m_rr    = (g + 1) % N;
            m_issued++;
        end else begin
            if (out_ready) m_valid = 0;
            if (|cmd_valid) m_stall++;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_out_cmd", out_cmd, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic rand_cmds();
        for (int i = 0; i < N; i++) cmd_flat[i*W +: W] = {$urandom, $urandom};
    endtask

    initial begin
        int exp_order [6];
        int grants;
        logic [W-1:0] held;
        exp_order = '{0, 3, 5, 0, 3, 5};
        model_clear();
        #2;
        do_reset();

        // Round robin over cores 0, 3, 5.
        cmd_valid = 8'b0010_1001; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_cmds();
            step();
            check("rr_order", obs_rdy, 64'(1) << exp_order[i]);
            check("rr_out_valid", out_valid, 1);
        end

        // Outstanding limit on core 2, then release by one response.
        do_reset();
        cmd_valid = 8'b0000_0100; out_ready = 1'b1; grants = 0;
        for (int i = 0; i < 6; i++) begin
            rand_cmds(); step();
            if (obs_rdy[2]) grants++;
        end
        check("limit_grants", grants, 4);
        check("limit_ready", obs_rdy[2], 0);
        resp_valid = 1'b1; resp_id = 3'd2;
        step();
        resp_valid = 1'b0; grants = 0;
        for (int i = 0; i < 4; i++) begin
            rand_cmds(); step();
            if (obs_rdy[2]) grants++;
        end
        check("release_grants", grants, 1);

        // Back-pressure with core 1.
        do_reset();
        cmd_valid = 8'b0000_0010; out_ready = 1'b0; rand_cmds();
        step();
        held = out_cmd;
        for (int i = 0; i < 4; i++) begin
            rand_cmds(); step();
            check("stall_hold", out_cmd, held);
        end
`ifdef CLUSTER_CMD_SCHED_STATS_EN
        check("stall_count", stat_stall, 4);
`else
        check("stall_count", stat_stall, 0);
`endif
        out_ready = 1'b1; cmd_valid = '0;
        step();

        // Simultaneous grant and response on core 4.
        do_reset();
        cmd_valid = 8'b0001_0000; out_ready = 1'b1;
        step(); step();
        resp_valid = 1'b1; resp_id = 3'd4;
        step();
        check("same_core_grant", obs_rdy, 8'b0001_0000);
        check("same_core_busy", busy, 1);
        cmd_valid = '0;
        step();
        check("drain_one_busy", busy, 1);
        step();
        check("drain_two_busy", busy, 0);
        resp_valid = 1'b0;

        // Bad response for idle core 6.
        resp_valid = 1'b1; resp_id = 3'd6;
        step();
        resp_valid = 1'b0;
        step(); step();
        check("err_sticky", err, 1);

        // Reset with a full output slot.
        cmd_valid = 8'b0000_1000; out_ready = 1'b0;
        step();
        check("full_before_rst", out_valid, 1);
        do_reset();
        cmd_valid = 8'b0000_0011; out_ready = 1'b1;
        step();
        check("rr_restart", obs_rdy, 8'b0000_0001);

        // Random traffic with legal responses.
        for (int cyc = 0; cyc < 400; cyc++) begin
            int pick;
            cmd_valid = N'($urandom);
            out_ready = ($urandom % 4) != 0;
            rand_cmds();
            resp_valid = 1'b0;
            if ($urandom % 2 == 0) begin
                pick = $urandom % N;
                for (int k = 0; k < N; k++) begin
                    if (!resp_valid && m_cnt[(pick + k) % N] > 0) begin
                        resp_valid = 1'b1;
                        resp_id    = IDW'((pick + k) % N);
                    end
                end
            end
            step();
        end
        resp_valid = 1'b0; cmd_valid = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/cluster_cmd_sched.md
CLUSTER_CMD_SCHED -- requirements
Module: cluster_cmd_sched

Interface
REQ-001 SHALL have parameter NUM_CORES, default 8: number of HPU command requesters.
REQ-002 SHALL have parameter CMD_WIDTH, default 64: flat width of one command word.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4: per-core limit on un-acknowledged commands, range 1..15.
REQ-004 SHALL have parameter CORE_ID_WIDTH, default $clog2(NUM_CORES): width of the core-id field carried by responses.
REQ-005 SHALL have ports clk_i (in, 1, sole clock) and rst_i (in, 1, reset); one clock; reset is asynchronous and active-high.
REQ-006 SHALL have ports cmd_valid_i (in, NUM_CORES), cmd_i (in, NUM_CORES*CMD_WIDTH) and cmd_ready_o (out, NUM_CORES): per-core request handshake.
REQ-007 SHALL have ports out_valid_o (out, 1), out_cmd_o (out, CMD_WIDTH), out_core_id_o (out, CORE_ID_WIDTH) and out_ready_i (in, 1): scheduled command toward the cluster command unit.
REQ-008 SHALL have ports resp_valid_i (in, 1) and resp_core_id_i (in, CORE_ID_WIDTH): command completion.
REQ-009 SHALL have ports busy_o (out, 1), meaning any outstanding count is nonzero, and err_o (out, 1), a sticky protocol error flag.
REQ-010 SHALL have ports stat_issued_o (out, 32) and stat_stall_o (out, 32): statistics counters.

Function
REQ-011 A core is eligible when cmd_valid_i[i]=1 and outstanding[i] < MAX_OUTSTANDING.
REQ-012 Grant SHALL be round-robin over eligible cores, starting the search at the rr pointer; at most one grant per cycle.
REQ-013 Grant SHALL occur only when the output slot is EMPTY, or is FULL with out_ready_i=1 in the same cycle (back-to-back issue, one command per cycle).
REQ-014 cmd_ready_o SHALL be the one-hot grant vector and combinational from the current inputs/state; it is all-zero when no grant occurs.
REQ-015 On grant, the output register SHALL load cmd_i[g] and g; out_valid_o asserts the next cycle (1-cycle latency).
REQ-016 Output slot states: EMPTY->FULL on grant; FULL->EMPTY on out_ready_i without grant; FULL->FULL on out_ready_i with grant (new data loaded); FULL held stable while out_ready_i=0.
REQ-017 The rr pointer SHALL move to (g+1) mod NUM_CORES on grant and is otherwise unchanged.
REQ-018 outstanding[g] SHALL increment on grant.
REQ-019 outstanding[resp_core_id_i] SHALL decrement on resp_valid_i.
REQ-020 A simultaneous grant and response for the same core SHALL leave that core's count unchanged.
REQ-021 A response for a core with count 0, or with resp_core_id_i >= NUM_CORES, SHALL be ignored and SHALL set err_o.
REQ-022 err_o SHALL stay set until reset.
REQ-023 Counters SHALL be 4 bits wide and SHALL never wrap.

Reset
REQ-024 On rst_i assertion, all state SHALL clear immediately: out_valid_o=0, out_cmd_o=0, out_core_id_o=0, rr pointer=0, all outstanding counts=0, err_o=0, stat_issued_o=0, stat_stall_o=0.
REQ-025 While rst_i=1, cmd_ready_o SHALL be all-zero.
REQ-026 A command held in the output slot when rst_i asserts SHALL be dropped and not re-presented.

Configuration
REQ-027 With macro CLUSTER_CMD_SCHED_STATS_EN defined, stat_issued_o SHALL count grants and stat_stall_o SHALL count cycles with any cmd_valid_i set and no grant; both saturate at 2^32-1.
REQ-028 Without CLUSTER_CMD_SCHED_STATS_EN, both statistics outputs SHALL be tied to 0 and no counter flops SHALL be instantiated.

Verification
REQ-029 Cores 0, 3 and 5 valid continuously, out_ready_i=1, no responses: grant order 0,3,5,0,3,5 with out_valid_o high from cycle 1.
REQ-030 Core 2 alone valid, MAX_OUTSTANDING=4, no responses: exactly 4 grants, then cmd_ready_o[2]=0; one response for core 2 gives exactly 1 more grant.
REQ-031 out_ready_i=0 for 5 cycles with core 1 valid: 1 grant, out_cmd_o stable for 5 cycles; stat_stall_o=4 (stats build) or 0 (non-stats build).
REQ-032 Grant to core 4 and response for core 4 in the same cycle, with count=2 beforehand: count remains 2 and busy_o=1.
REQ-033 Response for core 6 with count 0: count remains 0 and err_o=1 until rst_i asserts.
REQ-034 rst_i asserted while the output slot is FULL: out_valid_o=0 immediately and the rr pointer restarts at core 0.
